// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the instruction fetch memory.
// Optional feature macro: INSTR_MEM_PARITY_EN (per-word even parity).
package instr_mem_pkg;

    // Legal range of the fetch-to-valid latency.
    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 4;

    // NOP instruction fill bit; replicated to the instruction width at use,
    // so the NOP word is all zeros for any INSTR_WIDTH.
    localparam logic NOP_INSTR = 1'b0;

    // Instruction width of the reference stage layout below.
    localparam int STAGE_INSTR_WIDTH = 32;

    // One fetch pipeline stage. The top re-declares this layout at its own
    // INSTR_WIDTH and hands it to instr_mem_stage as a type parameter.
    typedef struct packed {
        logic                         valid;
        logic [STAGE_INSTR_WIDTH-1:0] data;
        logic                         addr_err;
        logic                         parity_err;
    } stage_t;

endpackage

// File: rtl/instr_mem_stage.sv
// One stall-able fetch pipeline register holding a complete stage record.
// Cleared by the asynchronous reset; holds its contents while i_en is low.
module instr_mem_stage
    import instr_mem_pkg::*;
#(
    parameter type stage_t_p = instr_mem_pkg::stage_t
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_en,
    input  stage_t_p i_d,
    output stage_t_p o_q
);

    stage_t_p r_q;

    // Capture the upstream stage when the pipeline advances, otherwise hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// Synchronous-read instruction memory with a program-load port and a
// valid/ready fetch interface feeding decode.
// Optional feature macro: INSTR_MEM_PARITY_EN -- stores an even-parity bit
// per word and flags mismatches on read; when undefined o_parity_err is 0.
module instr_fetch_mem
    import instr_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 2**ADDR_WIDTH,
    parameter int RD_LATENCY  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_load_en,
    input  logic [ADDR_WIDTH-1:0]  i_load_addr,
    input  logic [INSTR_WIDTH-1:0] i_load_data,
    input  logic                   i_fetch_req,
    input  logic [ADDR_WIDTH-1:0]  i_fetch_addr,
    output logic                   o_fetch_ready,
    output logic                   o_instr_valid,
    input  logic                   i_instr_ready,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic                   o_addr_err,
    output logic                   o_parity_err
);

    // Reject illegal configurations at elaboration.
    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $fatal(1, "instr_fetch_mem: RD_LATENCY %0d outside %0d..%0d",
               RD_LATENCY, RD_LATENCY_MIN, RD_LATENCY_MAX);
    end
    if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
        $fatal(1, "instr_fetch_mem: DEPTH %0d does not fit ADDR_WIDTH %0d",
               DEPTH, ADDR_WIDTH);
    end

`ifdef INSTR_MEM_PARITY_EN
    localparam int MEM_WIDTH = INSTR_WIDTH + 1;
`else
    localparam int MEM_WIDTH = INSTR_WIDTH;
`endif

    localparam logic [INSTR_WIDTH-1:0] NOP_WORD  = {INSTR_WIDTH{NOP_INSTR}};
    localparam logic [ADDR_WIDTH:0]    DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

    // Stage layout at this instance's instruction width.
    typedef struct packed {
        logic                   valid;
        logic [INSTR_WIDTH-1:0] data;
        logic                   addr_err;
        logic                   parity_err;
    } fetch_stage_t;

    logic [MEM_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                   w_advance;
    logic                   w_accept;
    logic                   w_load_in_range;
    logic                   w_fetch_in_range;
    logic [MEM_WIDTH-1:0]   w_wr_word;
    logic [MEM_WIDTH-1:0]   w_rd_word;
    logic [INSTR_WIDTH-1:0] w_rd_data;
    logic                   w_rd_parity_bad;
    fetch_stage_t           w_stage0_d;
    fetch_stage_t           w_stage_q [RD_LATENCY];
    fetch_stage_t           w_out;

    // The whole pipeline moves together; it only stops when decode refuses
    // a valid word. Loads own the cycle, so no fetch is taken alongside one.
    assign w_advance     = !w_out.valid || i_instr_ready;
    assign o_fetch_ready = !i_load_en && w_advance;
    assign w_accept      = i_fetch_req && o_fetch_ready;

    assign w_load_in_range  = {1'b0, i_load_addr}  < DEPTH_LIM;
    assign w_fetch_in_range = {1'b0, i_fetch_addr} < DEPTH_LIM;

`ifdef INSTR_MEM_PARITY_EN
    // Top bit is chosen so every stored word has even overall parity.
    assign w_wr_word       = {^i_load_data, i_load_data};
    assign w_rd_data       = w_rd_word[INSTR_WIDTH-1:0];
    assign w_rd_parity_bad = ^w_rd_word;
`else
    assign w_wr_word       = i_load_data;
    assign w_rd_data       = w_rd_word;
    assign w_rd_parity_bad = 1'b0;
`endif

    // Program load; out-of-range writes are silently dropped.
    always_ff @(posedge i_clk) begin
        if (i_load_en && w_load_in_range) begin
            r_mem[i_load_addr] <= w_wr_word;
        end
    end

    // Array read; stage 0 registers it, giving a synchronous-read memory.
    assign w_rd_word = r_mem[i_fetch_addr];

    // Build the stage-0 record: real data for in-range fetches, a NOP with
    // addr_err for out-of-range ones, and an empty slot when nothing is taken.
    always_comb begin
        w_stage0_d = '0;
        if (w_accept) begin
            w_stage0_d.valid = 1'b1;
            if (w_fetch_in_range) begin
                w_stage0_d.data       = w_rd_data;
                w_stage0_d.parity_err = w_rd_parity_bad;
            end else begin
                w_stage0_d.data     = NOP_WORD;
                w_stage0_d.addr_err = 1'b1;
            end
        end
    end

    // Chain of RD_LATENCY identical stall-able stages.
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_stage
        fetch_stage_t w_d;
        if (gi == 0) begin : g_first
            assign w_d = w_stage0_d;
        end else begin : g_next
            assign w_d = w_stage_q[gi-1];
        end
        instr_mem_stage #(
            .stage_t_p (fetch_stage_t)
        ) u_stage (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (w_advance),
            .i_d   (w_d),
            .o_q   (w_stage_q[gi])
        );
    end

    assign w_out         = w_stage_q[RD_LATENCY-1];
    assign o_instr_valid = w_out.valid;
    assign o_instr       = w_out.data;
    assign o_addr_err    = w_out.addr_err;
    assign o_parity_err  = w_out.parity_err;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: a cycle table on a latency-1 instance
// plus hand sequences for latency-3 timing, parity and mid-flight reset.
module tb_instr_fetch_mem;

    logic clk;
    logic rst;

    logic        a_load_en, a_fetch_req, a_instr_ready;
    logic [7:0]  a_load_addr, a_fetch_addr;
    logic [31:0] a_load_data, a_instr;
    logic        a_fetch_ready, a_instr_valid, a_addr_err, a_parity_err;

    logic        b_load_en, b_fetch_req, b_instr_ready;
    logic [7:0]  b_load_addr, b_fetch_addr;
    logic [31:0] b_load_data, b_instr;
    logic        b_fetch_ready, b_instr_valid, b_addr_err, b_parity_err;

    int n_vec = 0;
    int n_bad = 0;

    instr_fetch_mem #(
        .ADDR_WIDTH(8), .INSTR_WIDTH(32), .DEPTH(200), .RD_LATENCY(1)
    ) u_dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_load_en(a_load_en), .i_load_addr(a_load_addr), .i_load_data(a_load_data),
        .i_fetch_req(a_fetch_req), .i_fetch_addr(a_fetch_addr), .o_fetch_ready(a_fetch_ready),
        .o_instr_valid(a_instr_valid), .i_instr_ready(a_instr_ready), .o_instr(a_instr),
        .o_addr_err(a_addr_err), .o_parity_err(a_parity_err)
    );

    instr_fetch_mem #(
        .ADDR_WIDTH(8), .INSTR_WIDTH(32), .DEPTH(200), .RD_LATENCY(3)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_load_en(b_load_en), .i_load_addr(b_load_addr), .i_load_data(b_load_data),
        .i_fetch_req(b_fetch_req), .i_fetch_addr(b_fetch_addr), .o_fetch_ready(b_fetch_ready),
        .o_instr_valid(b_instr_valid), .i_instr_ready(b_instr_ready), .o_instr(b_instr),
        .o_addr_err(b_addr_err), .o_parity_err(b_parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ld;
        logic [7:0]  la;
        logic [31:0] ldat;
        logic        fq;
        logic [7:0]  fa;
        logic        rdy;
        logic        e_fr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic        e_ae;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ld, input logic [7:0] la, input logic [31:0] ldat,
                                input logic fq, input logic [7:0] fa, input logic rdy,
                                input logic e_fr, input logic e_iv, input logic [31:0] e_instr,
                                input logic e_ae);
        vec_t v;
        v.ld = ld; v.la = la; v.ldat = ldat; v.fq = fq; v.fa = fa; v.rdy = rdy;
        v.e_fr = e_fr; v.e_iv = e_iv; v.e_instr = e_instr; v.e_ae = e_ae;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [31:0] e_data;
        logic        e_pe;

        rst = 1'b1;
        a_load_en = 1'b0; a_load_addr = '0; a_load_data = '0;
        a_fetch_req = 1'b0; a_fetch_addr = '0; a_instr_ready = 1'b1;
        b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0;
        b_fetch_req = 1'b0; b_fetch_addr = '0; b_instr_ready = 1'b1;

        // Cycle table for the latency-1 instance (DEPTH=200).
        //              ld   la     ldat           fq   fa      rdy   fr   iv   instr          ae
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 8'd0,   32'h11111111, 1'b1, 8'd0,   1'b1, 1'b0, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 8'd1,   32'h22222222, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 8'd2,   32'h33333333, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 8'd3,   32'h44444444, 1'b0, 8'd0,   1'b1, 1'b0, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd0,   1'b1, 1'b1, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd1,   1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd2,   1'b1, 1'b1, 1'b1, 32'h22222222, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd3,   1'b1, 1'b1, 1'b1, 32'h33333333, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 32'h44444444, 1'b0));
        // load and fetch together: load wins, fetch retried next cycle
        vecs.push_back(mk(1'b1, 8'd5,   32'hDEADBEEF, 1'b1, 8'd5,   1'b1, 1'b0, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd5,   1'b1, 1'b1, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd250, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0));
        // out-of-range load is dropped; out-of-range fetches return NOP + addr_err
        vecs.push_back(mk(1'b1, 8'd250, 32'hCAFEF00D, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd250, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd200, 1'b1, 1'b1, 1'b1, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd3,   1'b1, 1'b1, 1'b1, 32'h0,        1'b1));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 32'h44444444, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 32'h0,        1'b0));
        // stream with a 5-cycle decode stall, plus a load during the stall
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd0,   1'b1, 1'b1, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd1,   1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd2,   1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd2,   1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0));
        vecs.push_back(mk(1'b1, 8'd1,   32'h55555555, 1'b1, 8'd2,   1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd2,   1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd2,   1'b0, 1'b0, 1'b1, 32'h22222222, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd2,   1'b1, 1'b1, 1'b1, 32'h22222222, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd3,   1'b1, 1'b1, 1'b1, 32'h33333333, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd1,   1'b1, 1'b1, 1'b1, 32'h44444444, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 32'h55555555, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 32'h0,        1'b0));
        // empty pipeline advances even with decode not ready
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b1, 8'd0,   1'b0, 1'b1, 1'b0, 32'h0,        1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b0, 8'd0,   1'b1, 1'b1, 1'b1, 32'h11111111, 1'b0));
        vecs.push_back(mk(1'b0, 8'd0,   32'h0,        1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 32'h0,        1'b0));

        // Reset, release away from the clock edge, check reset state.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("rst_a_fetch_ready", a_fetch_ready, 1'b1);
        chk1("rst_a_instr_valid", a_instr_valid, 1'b0);
        chk32("rst_a_instr", a_instr, 32'h0);
        chk1("rst_a_addr_err", a_addr_err, 1'b0);
        chk1("rst_a_parity_err", a_parity_err, 1'b0);
        chk1("rst_b_instr_valid", b_instr_valid, 1'b0);
        chk32("rst_b_instr", b_instr, 32'h0);
        $display("reset: a_fr=%0b a_iv=%0b b_iv=%0b", a_fetch_ready, a_instr_valid, b_instr_valid);

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            a_load_en = vecs[i].ld; a_load_addr = vecs[i].la; a_load_data = vecs[i].ldat;
            a_fetch_req = vecs[i].fq; a_fetch_addr = vecs[i].fa; a_instr_ready = vecs[i].rdy;
            @(negedge clk);
            $display("vec %0d: ld=%0b fq=%0b fa=%0d rdy=%0b -> fr=%0b iv=%0b instr=%h ae=%0b pe=%0b",
                     i, vecs[i].ld, vecs[i].fq, vecs[i].fa, vecs[i].rdy,
                     a_fetch_ready, a_instr_valid, a_instr, a_addr_err, a_parity_err);
            chk1($sformatf("vec%0d_fetch_ready", i), a_fetch_ready, vecs[i].e_fr);
            chk1($sformatf("vec%0d_instr_valid", i), a_instr_valid, vecs[i].e_iv);
            if (vecs[i].e_iv) begin
                chk32($sformatf("vec%0d_instr", i), a_instr, vecs[i].e_instr);
                chk1($sformatf("vec%0d_addr_err", i), a_addr_err, vecs[i].e_ae);
                chk1($sformatf("vec%0d_parity_err", i), a_parity_err, 1'b0);
            end
            @(posedge clk); #1;
        end
        a_load_en = 1'b0; a_fetch_req = 1'b0; a_instr_ready = 1'b1;

        // Latency-3 instance: load 0..3, fetch back-to-back, first word
        // visible in the third cycle after acceptance.
        for (int i = 0; i < 4; i++) begin
            b_load_en = 1'b1; b_load_addr = 8'(i); b_load_data = 32'(32'h11111111 * (i + 1));
            @(posedge clk); #1;
        end
        b_load_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            b_fetch_req = (c < 4); b_fetch_addr = 8'(c);
            @(negedge clk);
            $display("lat3 cycle %0d: fr=%0b iv=%0b instr=%h", c, b_fetch_ready, b_instr_valid, b_instr);
            chk1($sformatf("lat3_c%0d_fetch_ready", c), b_fetch_ready, 1'b1);
            chk1($sformatf("lat3_c%0d_instr_valid", c), b_instr_valid, (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                chk32($sformatf("lat3_c%0d_instr", c), b_instr, 32'(32'h11111111 * (c - 2)));
            end
            @(posedge clk); #1;
        end
        b_fetch_req = 1'b0;

        // Parity: load addr 7, optionally corrupt one stored bit, fetch it.
        a_load_en = 1'b1; a_load_addr = 8'd7; a_load_data = 32'h0F0F0F0F;
        @(posedge clk); #1;
        a_load_en = 1'b0;
`ifdef INSTR_MEM_PARITY_EN
        u_dut_a.r_mem[7][0] = ~u_dut_a.r_mem[7][0];
        e_data = 32'h0F0F0F0E; e_pe = 1'b1;
`else
        e_data = 32'h0F0F0F0F; e_pe = 1'b0;
`endif
        a_fetch_req = 1'b1; a_fetch_addr = 8'd7;
        @(negedge clk);
        chk1("par_fetch_ready", a_fetch_ready, 1'b1);
        @(posedge clk); #1;
        a_fetch_req = 1'b0;
        @(negedge clk);
        $display("parity fetch 7: iv=%0b instr=%h ae=%0b pe=%0b", a_instr_valid, a_instr, a_addr_err, a_parity_err);
        chk1("par_instr_valid", a_instr_valid, 1'b1);
        chk32("par_instr", a_instr, e_data);
        chk1("par_addr_err", a_addr_err, 1'b0);
        chk1("par_parity_err", a_parity_err, e_pe);

        // Reset with three fetches in flight on the latency-3 instance.
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            b_fetch_req = 1'b1; b_fetch_addr = 8'(c);
            @(posedge clk); #1;
        end
        b_fetch_req = 1'b0;
        #1;
        chk1("flush_pre_valid", b_instr_valid, 1'b1);
        chk32("flush_pre_instr", b_instr, 32'h11111111);
        rst = 1'b1;
        #1;
        $display("async reset: b_iv=%0b b_instr=%h", b_instr_valid, b_instr);
        chk1("flush_async_valid", b_instr_valid, 1'b0);
        chk32("flush_async_instr", b_instr, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk1($sformatf("flush_post_c%0d_b_valid", c), b_instr_valid, 1'b0);
            chk1($sformatf("flush_post_c%0d_a_valid", c), a_instr_valid, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
